// File: rtl/chan_mux_pkg.sv
// Shared types and default sizing for the channel scan multiplexer.
package chan_mux_pkg;

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  localparam int unsigned N_IN_DEF    = 6;
  localparam int unsigned SEL_W_DEF   = 3;
  localparam int unsigned DWELL_W_DEF = 4;

endpackage

// File: rtl/chan_scan_mux_if.sv
// Control/data bundle between the switch inputs and the indicator logic.
interface chan_scan_mux_if
  import chan_mux_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) ();

  logic [N_IN-1:0]    in;
  logic [SEL_W-1:0]   sel;
  logic               mode;
  logic               hold;
  logic [DWELL_W-1:0] dwell;
  logic               out;
  logic [SEL_W-1:0]   cur_sel;
  logic               wrap;
  logic               bad_sel;

  modport master (
    output in, sel, mode, hold, dwell,
    input  out, cur_sel, wrap, bad_sel
  );

  modport slave (
    input  in, sel, mode, hold, dwell,
    output out, cur_sel, wrap, bad_sel
  );

endinterface

// File: rtl/chan_scan_mux_scan_counter.sv
// Channel index and dwell counter; flags the N_IN-1 -> 0 wrap step.
module scan_counter
  import chan_mux_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               load,
  input  logic [SEL_W-1:0]   load_sel,
  input  logic               restart,
  input  logic               enable,
  input  logic               keep,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   cur_sel,
  output logic               wrap_c
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
  logic               step_c;
  logic               last_c;

  // >= so that lowering dwell below the running count advances immediately
  assign step_c  = (cnt_q >= dwell);
  assign last_c  = (cur_sel_q == SEL_W'(N_IN - 1));
  assign wrap_c  = enable && step_c && last_c;
  assign cur_sel = cur_sel_q;

  always_comb begin
    cnt_d     = keep ? cnt_q : '0;
    cur_sel_d = cur_sel_q;
    if (load) begin
      cur_sel_d = load_sel;
      cnt_d     = '0;
    end else if (restart) begin
      cur_sel_d = '0;
      cnt_d     = '0;
    end else if (enable) begin
      if (step_c) begin
        cnt_d     = '0;
        cur_sel_d = last_c ? '0 : cur_sel_q + SEL_W'(1);
      end else begin
        cnt_d = cnt_q + DWELL_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      cur_sel_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// N-input 1-bit channel selector with manual select and pausable auto-scan.
module chan_scan_mux
  import chan_mux_pkg::*;
#(
  parameter int unsigned N_IN    = N_IN_DEF,
  parameter int unsigned SEL_W   = SEL_W_DEF,
  parameter int unsigned DWELL_W = DWELL_W_DEF
) (
  input  logic            clock,
  input  logic            resetn,
  chan_scan_mux_if.slave  bus
);

  state_e           state_q, state_d;
  logic             out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             bad_sel_q, bad_sel_d;
  logic             load, restart, enable, keep;
  logic             wrap_c;
  logic             sel_bad_c;
  logic [SEL_W-1:0] eff_sel_c;
  logic [SEL_W-1:0] cur_sel;

  scan_counter #(
    .N_IN    (N_IN),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan_counter (
    .clock    (clock),
    .resetn   (resetn),
    .load     (load),
    .load_sel (bus.sel),
    .restart  (restart),
    .enable   (enable),
    .keep     (keep),
    .dwell    (bus.dwell),
    .cur_sel  (cur_sel),
    .wrap_c   (wrap_c)
  );

  // Extra bit keeps the compare valid when N_IN == 2**SEL_W
  assign sel_bad_c = ({1'b0, bus.sel} >= (SEL_W + 1)'(N_IN));

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    restart   = 1'b0;
    enable    = 1'b0;
    keep      = 1'b0;
    bad_sel_d = 1'b0;
    case (state_q)
      S_MAN: begin
        bad_sel_d = sel_bad_c;
        if (bus.mode) begin
          state_d = S_SCAN;
          restart = 1'b1;
        end else begin
          load = 1'b1;
        end
      end
      S_SCAN: begin
        if (!bus.mode) begin
          state_d = S_MAN;
        end else if (bus.hold) begin
          state_d = S_HOLD;
          keep    = 1'b1;
        end else begin
          enable = 1'b1;
        end
      end
      S_HOLD: begin
        if (!bus.mode) begin
          state_d = S_MAN;
        end else begin
          keep = 1'b1;
          if (!bus.hold) state_d = S_SCAN;
        end
      end
      default: state_d = S_MAN;
    endcase

    wrap_d    = wrap_c;
    eff_sel_c = (state_q == S_MAN) ? bus.sel : cur_sel;
    // Out-of-range selects match no channel and read as 0
    out_d = 1'b0;
    for (int i = 0; i < int'(N_IN); i++) begin
      if (eff_sel_c == SEL_W'(i)) out_d = bus.in[i];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_MAN;
      out_q     <= 1'b0;
      wrap_q    <= 1'b0;
      bad_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      wrap_q    <= wrap_d;
      bad_sel_q <= bad_sel_d;
    end
  end

  assign bus.out     = out_q;
  assign bus.cur_sel = cur_sel;
  assign bus.wrap    = wrap_q;
  assign bus.bad_sel = bad_sel_q;

endmodule
